enigma_target: RTL
==================

# enigma_target

Downstream responder for the ENIGMA buffer's output channel (port c). It accepts beats on the valid_c/ready_c handshake and holds each accepted id in an outstanding-slot table. Each entry is released after a QoS-dependent latency by pulsing release_c with releaseid_c, and conflict_c is pulsed for any beat whose id is already outstanding. It is the synthesizable/bench counterpart that closes the loop on the buffer's output and release/conflict protocol.

## Interface
- SLOTS, 8: outstanding-table depth (power of 2, 2..32)
- BASE_LAT, 4: minimum hold latency in cycles (>=1)
- QOS_STEP, 2: extra cycles per QoS level below 3
- clk  input  1  clock, all logic rising-edge
- rst_n  input  1  reset, asynchronous assert, active-low
- valid_c  input  1  beat valid from buffer
- payload_c  input  128  beat payload
- id_c  input  6  beat id
- qos_c  input  2  beat QoS (3 = highest)
- hold_ready  input  1  bench backpressure; forces ready_c low
- ready_c  output  1  target can accept
- conflict_c  output  1  one-cycle pulse: last accepted beat's id was outstanding
- release_c  output  1  one-cycle pulse: entry released
- releaseid_c  output  6  id of released entry, valid with release_c
- accept_cnt  output  32  beats stored (non-conflicting)
- conflict_cnt  output  16  beats rejected as conflicting
- payload_chk  output  128  XOR of all stored payloads

## Operation
- Slot state: vld, id[5:0], cnt[LAT_W-1:0]. LAT_W sized for BASE_LAT+3*QOS_STEP.
- ready_c = !hold_ready && (occupancy < SLOTS); occupancy is registered popcount of vld. Combinational from registers only, never from valid_c.
- Handshake: valid_c && ready_c at a rising edge.
- On handshake, id_c compared against all slots with vld=1, including a slot releasing at the same edge.
  - Match: beat dropped, conflict_c=1 next cycle, conflict_cnt+1 (saturating at 0xFFFF).
  - No match: written to lowest-index slot free before this edge; cnt = BASE_LAT + (3-qos_c)*QOS_STEP; accept_cnt+1 (wraps); payload_chk ^= payload_c.
- Countdown: each vld slot with cnt>0 decrements every edge.
- Release: among vld slots with cnt==0, lowest index selected each edge; slot vld cleared, release_c=1, releaseid_c=slot id registered. Unselected zero-count slots wait, at most one release per cycle.
- A slot freed at an edge is not reusable at that same edge.
- Simultaneous accept + release at one edge: both happen; occupancy net unchanged.
- valid_c without ready_c: no state change; the buffer holds the beat.
- conflict_c and release_c may be high in the same cycle.

## Timing
- Reset (async, any time including mid-operation): all vld=0, ready_c reflects empty (1 unless hold_ready), conflict_c=0, release_c=0, releaseid_c=0, accept_cnt=0, conflict_cnt=0, payload_chk=0. Outstanding entries are discarded without release.
- Accept at edge E0 with delay D: release_c high in the cycle after edge E0+D+1, i.e. D+1 cycles after the accepting edge, if no lower-index slot contends.
- conflict_c: high exactly the one cycle following the accepting edge.
- ready_c drops the cycle after the edge that fills the last slot; rises the cycle after the releasing edge.
- Throughput: one beat per cycle while slots are free; one release per cycle.

## Test plan
- Single beat id=5, qos=3, payload=0x1 at edge E0 -> release_c=1, releaseid_c=5 in the cycle after E0+5; accept_cnt=1, payload_chk=0x1.
- qos=0 beat id=7 -> release 11 cycles after accept edge; qos=3 id=8 accepted 3 cycles later -> releases first (id 8 before id 7).
- Fill 8 slots ids 0..7 back-to-back with hold release long -> ready_c low after 8th edge; beat id=9 held on valid_c accepted only after first release; no beat lost.
- Beat id=3 while id=3 outstanding -> conflict_c pulse one cycle, conflict_cnt=1, accept_cnt unchanged, only one release of id 3.
- Two beats ids 1,2 same qos on consecutive edges, plus id=4 accepted at the edge id 1 releases -> releases 1,2 on successive cycles; occupancy correct; no slot-reuse corruption.
- Assert rst_n low with 4 entries outstanding -> all outputs to reset values immediately; no release_c after deassertion; ready_c=1.

Source files
------------

// File: rtl/enigma_target.sv
// Downstream responder for the ENIGMA buffer output channel: holds accepted ids
// in an outstanding table, releases each after a QoS-dependent latency, flags id conflicts.
module enigma_target #(
   parameter int SLOTS    = 8,
   parameter int BASE_LAT = 4,
   parameter int QOS_STEP = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_c,
   input  logic [127:0] payload_c,
   input  logic [5:0]   id_c,
   input  logic [1:0]   qos_c,
   input  logic         hold_ready,
   output logic         ready_c,
   output logic         conflict_c,
   output logic         release_c,
   output logic [5:0]   releaseid_c,
   output logic [31:0]  accept_cnt,
   output logic [15:0]  conflict_cnt,
   output logic [127:0] payload_chk
);

   localparam int MAX_LAT = BASE_LAT + 3 * QOS_STEP;
   localparam int LAT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
   localparam int IDX_W   = (SLOTS < 2) ? 1 : $clog2(SLOTS);
   localparam int OCC_W   = $clog2(SLOTS + 1);

   logic [SLOTS-1:0] slot_vld;
   logic [5:0]       slot_id  [SLOTS];
   logic [LAT_W-1:0] slot_cnt [SLOTS];

   logic [OCC_W-1:0] occupancy;
   logic             handshake;
   logic             id_match;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic             rel_found;
   logic [IDX_W-1:0] rel_idx;
   logic             accept_new;
   logic [LAT_W-1:0] new_lat;

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < SLOTS; i++) begin
         occupancy = occupancy + OCC_W'(slot_vld[i]);
      end
   end

   assign ready_c   = !hold_ready && (occupancy < OCC_W'(SLOTS));
   assign handshake = valid_c && ready_c;

   // Descending scan so the lowest qualifying index wins; all selections use
   // pre-edge state, so a slot releasing now still conflicts and is not reused.
   always_comb begin
      id_match   = 1'b0;
      free_found = 1'b0;
      free_idx   = '0;
      rel_found  = 1'b0;
      rel_idx    = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (slot_vld[i] && (slot_id[i] == id_c)) begin
            id_match = 1'b1;
         end
         if (!slot_vld[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (slot_vld[i] && (slot_cnt[i] == '0)) begin
            rel_found = 1'b1;
            rel_idx   = IDX_W'(i);
         end
      end
   end

   assign accept_new = handshake && !id_match && free_found;
   assign new_lat    = LAT_W'(BASE_LAT + (3 - int'(qos_c)) * QOS_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_vld <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            slot_id[i]  <= '0;
            slot_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            if (slot_vld[i] && (slot_cnt[i] != '0)) begin
               slot_cnt[i] <= slot_cnt[i] - LAT_W'(1);
            end
         end
         if (rel_found) begin
            slot_vld[rel_idx] <= 1'b0;
         end
         if (accept_new) begin
            slot_vld[free_idx] <= 1'b1;
            slot_id[free_idx]  <= id_c;
            slot_cnt[free_idx] <= new_lat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_c   <= 1'b0;
         release_c    <= 1'b0;
         releaseid_c  <= '0;
         accept_cnt   <= '0;
         conflict_cnt <= '0;
         payload_chk  <= '0;
      end else begin
         conflict_c <= handshake && id_match;
         release_c  <= rel_found;
         if (rel_found) begin
            releaseid_c <= slot_id[rel_idx];
         end
         if (accept_new) begin
            accept_cnt  <= accept_cnt + 32'd1;
            payload_chk <= payload_chk ^ payload_c;
         end
         if (handshake && id_match && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
         end
      end
   end

endmodule
